// File: rtl/mm_rd_arbiter.sv
// Two-master to one-slave Avalon-MM read arbiter. It uses round-robin priority and
// holds the grant while the slave stalls. A tag FIFO routes in-order read data back.
module mm_rd_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4,
    localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,

    output logic [CNT_W-1:0]  outstanding,
    output logic              err_orphan
);

    logic                 lock_q, lock_d;
    logic                 lock_id_q, lock_id_d;
    logic                 rr_pri_q, rr_pri_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     outst_q, outst_d;
    // Tag FIFO as a shift register: bit 0 is always the head.
    logic [MAX_OUTST-1:0] tags_q, tags_d;

    logic             gnt_valid;
    logic             gnt_id;
    logic             gnt_read;
    logic             full;
    logic             accept;
    logic             pop;
    logic [CNT_W-1:0] wr_cnt;

    // NOTE: every signal gets a default at the top of always_comb, so no path can leave it unassigned and infer a latch.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (lock_q) begin
            gnt_valid = 1'b1;
            gnt_id    = lock_id_q;
        end else if (m0_read && m1_read) begin
            gnt_valid = 1'b1;
            gnt_id    = rr_pri_q;
        end else if (m0_read) begin
            gnt_valid = 1'b1;
        end else if (m1_read) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b1;
        end
    end

    assign full     = (outst_q == CNT_W'(MAX_OUTST));
    assign gnt_read = gnt_valid && (gnt_id ? m1_read : m0_read);
    assign s_read   = gnt_read && !full;
    assign accept   = s_read && !s_waitrequest;
    assign pop      = s_readdatavalid && (outst_q != '0);

    assign s_address = !gnt_valid ? '0 : (gnt_id ? m1_address : m0_address);

    // Only the granted master can ever see waitrequest low.
    assign m0_waitrequest = (gnt_valid && !gnt_id) ? (s_waitrequest || full) : 1'b1;
    assign m1_waitrequest = (gnt_valid &&  gnt_id) ? (s_waitrequest || full) : 1'b1;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop && !tags_q[0];
    assign m1_readdatavalid = pop &&  tags_q[0];

    assign outstanding = outst_q;
    assign err_orphan  = err_q;

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        rr_pri_d  = rr_pri_q;
        if (accept) begin
            lock_d   = 1'b0;
            rr_pri_d = ~gnt_id;
        end else if (s_read) begin
            // The slave stalled an issued read, so the grant is held until it is accepted.
            lock_d    = 1'b1;
            lock_id_d = gnt_id;
        end else if (lock_q && !gnt_read) begin
            lock_d = 1'b0;
        end

        err_d   = err_q || (s_readdatavalid && (outst_q == '0));
        outst_d = outst_q + CNT_W'(accept) - CNT_W'(pop);

        // The write slot is computed after the pop shift, so a push and a pop can happen in the same cycle.
        wr_cnt = outst_q - CNT_W'(pop);
        tags_d = pop ? (tags_q >> 1) : tags_q;
        for (int i = 0; i < MAX_OUTST; i++) begin
            if (accept && (CNT_W'(i) == wr_cnt)) begin
                tags_d[i] = gnt_id;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            rr_pri_q  <= 1'b0;
            err_q     <= 1'b0;
            outst_q   <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rr_pri_q  <= rr_pri_d;
            err_q     <= err_d;
            outst_q   <= outst_d;
        end
    end

    // NOTE: tag storage has no reset. Only entries below outst_q are ever read, so clearing the count empties the FIFO.
    always_ff @(posedge clk) begin
        tags_q <= tags_d;
    end

endmodule

// File: tb/tb_mm_rd_arbiter.sv
// Directed bench for mm_rd_arbiter. A queue-based transaction model is checked against
// the DUT on every negedge, and hand-computed literal checks are made at scenario points.
module tb_mm_rd_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int MAX_OUTST = 4;
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] m0_address, m1_address, s_address;
    logic              m0_read, m1_read, s_read;
    logic              m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
    logic              m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
    logic [CNT_W-1:0]  outstanding;
    logic              err_orphan;

    int n_checks = 0;
    int n_errors = 0;

    mm_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: queue of accepted master IDs in return order,
    // plus the master whose stalled read must finish before anyone else is served.
    bit        q[$];
    bit        busy, owner, turn, merr;
    bit        e_gv, e_g, e_gread, e_room, e_sread, e_pop, e_head, e_acc;
    bit [31:0] e_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            busy = 0; owner = 0; turn = 0; merr = 0;
        end
        e_gv = 1; e_g = 0;
        if (busy)                      e_g = owner;
        else if (m0_read && m1_read)   e_g = turn;
        else if (m0_read)              e_g = 0;
        else if (m1_read)              e_g = 1;
        else                           e_gv = 0;
        e_room  = q.size() < MAX_OUTST;
        e_gread = e_gv && (e_g ? m1_read : m0_read);
        e_sread = e_gread && e_room;
        e_addr  = !e_gv ? 32'h0 : (e_g ? m1_address : m0_address);
        e_pop   = s_readdatavalid && (q.size() > 0);
        e_head  = (q.size() > 0) ? q[0] : 1'b0;

        check("cmp s_read", s_read, e_sread);
        check("cmp s_address", s_address, e_addr);
        check("cmp m0_waitrequest", m0_waitrequest, (e_gv && !e_g) ? (s_waitrequest || !e_room) : 1'b1);
        check("cmp m1_waitrequest", m1_waitrequest, (e_gv && e_g) ? (s_waitrequest || !e_room) : 1'b1);
        check("cmp m0_readdatavalid", m0_readdatavalid, e_pop && !e_head);
        check("cmp m1_readdatavalid", m1_readdatavalid, e_pop && e_head);
        check("cmp m0_readdata", m0_readdata, s_readdata);
        check("cmp m1_readdata", m1_readdata, s_readdata);
        check("cmp outstanding", 64'(outstanding), 64'(q.size()));
        check("cmp err_orphan", err_orphan, merr);

        if (rst_n) begin
            if (s_readdatavalid && q.size() == 0) merr = 1;
            e_acc = e_sread && !s_waitrequest;
            if (e_pop) void'(q.pop_front());
            if (e_acc) q.push_back(e_g);
            if (e_acc) begin
                busy = 0;
                turn = !e_g;
            end else if (e_sread) begin
                busy  = 1;
                owner = e_g;
            end else if (busy && !e_gread) begin
                busy = 0;
            end
        end
    end

    task automatic drive(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                         input logic sw, input logic rv, input logic [63:0] rd);
        @(posedge clk);
        #1;
        m0_read = r0; m0_address = a0;
        m1_read = r1; m1_address = a1;
        s_waitrequest = sw; s_readdatavalid = rv; s_readdata = rd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 64'h0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst_n = 0;
        m0_read = 0; m1_read = 0; s_waitrequest = 0; s_readdatavalid = 0;
        #2;
        check("lit reset outstanding", 64'(outstanding), 64'd0);
        check("lit reset err_orphan", err_orphan, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        m0_read = 0; m0_address = 0; m1_read = 0; m1_address = 0;
        s_waitrequest = 0; s_readdatavalid = 0; s_readdata = 0;

        // Reset state, with a stray return strobe held during reset
        repeat (2) @(posedge clk);
        #1;
        s_readdatavalid = 1; s_readdata = 64'hDEAD;
        #2;
        check("lit rst m0_readdatavalid", m0_readdatavalid, 1'b0);
        check("lit rst m1_readdatavalid", m1_readdatavalid, 1'b0);
        check("lit rst outstanding", 64'(outstanding), 64'd0);
        check("lit rst m0_waitrequest", m0_waitrequest, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1; s_readdatavalid = 0;

        // Single read from m0
        drive(1, 32'h10, 0, 0, 0, 0, 64'h0);
        #2;
        check("lit first s_read", s_read, 1'b1);
        check("lit first s_address", s_address, 32'h10);
        check("lit first m0_waitrequest", m0_waitrequest, 1'b0);
        idle();
        #2;
        check("lit first outstanding", 64'(outstanding), 64'd1);
        // rr_pri is now m1, and m0's return arrives in the same cycle
        drive(1, 32'h20, 1, 32'h24, 0, 1, 64'hA1);
        #2;
        check("lit rr_pri grants m1", s_address, 32'h24);
        check("lit m0 return strobe", m0_readdatavalid, 1'b1);
        idle();
        #2;
        check("lit push+pop outstanding", 64'(outstanding), 64'd1);
        drive(0, 0, 0, 0, 0, 1, 64'hA2);
        #2;
        check("lit m1 return strobe", m1_readdatavalid, 1'b1);
        idle();

        // Both masters request every cycle; the data returns two cycles later
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, 32'h100 + 32'(4*i), i < 4, 32'h200 + 32'(4*i), 0, i >= 2, 64'hD0 + 64'(i));
            #2;
            if (i < 4)
                check("lit alt s_address", s_address, (i % 2 == 0) ? 32'h100 + 32'(4*i) : 32'h200 + 32'(4*i));
            if (i == 3) check("lit same-cycle outstanding", 64'(outstanding), 64'd2);
            check("lit alt m0 strobe", m0_readdatavalid, (i >= 2) && (i % 2 == 0));
            check("lit alt m1 strobe", m1_readdatavalid, (i >= 2) && (i % 2 == 1));
        end
        idle();

        // m1 holds the grant through three slave stalls while m0 waits
        drive(0, 0, 1, 32'h300, 1, 0, 64'h0);
        #2;
        check("lit stall s_address c1", s_address, 32'h300);
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h400, 1, 32'h300, 1, 0, 64'h0);
            #2;
            check("lit stall s_address", s_address, 32'h300);
            check("lit stall m0_waitrequest", m0_waitrequest, 1'b1);
        end
        drive(1, 32'h400, 1, 32'h300, 0, 0, 64'h0);
        #2;
        check("lit stall accept m1", m1_waitrequest, 1'b0);
        check("lit stall accept addr", s_address, 32'h300);
        drive(1, 32'h400, 0, 0, 0, 0, 64'h0);
        drive(0, 0, 0, 0, 0, 1, 64'hE0);
        #2;
        check("lit stall ret m1", m1_readdatavalid, 1'b1);
        drive(0, 0, 0, 0, 0, 1, 64'hE1);
        #2;
        check("lit stall ret m0", m0_readdatavalid, 1'b1);

        // The locked master drops its read; the lock is released with no push
        drive(1, 32'h500, 0, 0, 1, 0, 64'h0);
        drive(0, 0, 1, 32'h600, 0, 0, 64'h0);
        #2;
        check("lit violation s_read", s_read, 1'b0);
        check("lit violation m1_waitrequest", m1_waitrequest, 1'b1);
        drive(0, 0, 1, 32'h600, 0, 0, 64'h0);
        #2;
        check("lit violation m1 accepted", s_read, 1'b1);
        drive(0, 0, 0, 0, 0, 1, 64'hE2);
        #2;
        check("lit violation ret m1", m1_readdatavalid, 1'b1);

        // Five back-to-back reads fill the FIFO, and one return frees a slot
        for (int i = 0; i < 4; i++) drive(1, 32'h700 + 32'(4*i), 0, 0, 0, 0, 64'h0);
        drive(1, 32'h710, 0, 0, 0, 0, 64'h0);
        #2;
        check("lit full outstanding", 64'(outstanding), 64'd4);
        check("lit full s_read", s_read, 1'b0);
        check("lit full m0_waitrequest", m0_waitrequest, 1'b1);
        drive(1, 32'h710, 0, 0, 0, 1, 64'hF0);
        #2;
        check("lit full pop s_read", s_read, 1'b0);
        check("lit full pop strobe", m0_readdatavalid, 1'b1);
        drive(1, 32'h710, 0, 0, 0, 0, 64'h0);
        #2;
        check("lit refill outstanding", 64'(outstanding), 64'd3);
        check("lit refill s_read", s_read, 1'b1);
        idle();
        #2;
        check("lit refilled outstanding", 64'(outstanding), 64'd4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, 64'hF1 + 64'(i));
            #2;
            check("lit drain m0 strobe", m0_readdatavalid, 1'b1);
        end
        idle();

        // Reset drops the outstanding tags, so the later return is an orphan
        drive(0, 0, 1, 32'h800, 0, 0, 64'h0);
        reset_pulse();
        drive(1, 32'h900, 0, 0, 0, 1, 64'hBAD);
        #2;
        check("lit orphan m0 strobe", m0_readdatavalid, 1'b0);
        check("lit orphan m1 strobe", m1_readdatavalid, 1'b0);
        check("lit orphan accept", s_read, 1'b1);
        idle();
        #2;
        check("lit orphan err set", err_orphan, 1'b1);
        check("lit orphan push kept", 64'(outstanding), 64'd1);
        repeat (3) idle();
        drive(0, 0, 0, 0, 0, 1, 64'hC0);
        #2;
        check("lit post-orphan strobe", m0_readdatavalid, 1'b1);
        idle();
        #2;
        check("lit err sticky", err_orphan, 1'b1);
        reset_pulse();
        idle();
        #2;
        check("lit err cleared", err_orphan, 1'b0);
        repeat (2) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mm_rd_arbiter.md
MM_RD_ARBITER -- requirements
Module: mm_rd_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width on all ports.
REQ-002 Parameter DATA_W, default 64: readdata width on all ports.
REQ-003 Parameter MAX_OUTST, default 4: max accepted-but-unreturned reads; the tag FIFO depth.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 m0_address  in  ADDR_W  master 0 read address.
REQ-007 m0_read  in  1  master 0 read request.
REQ-008 m0_waitrequest  out  1  master 0 stall.
REQ-009 m0_readdata  out  DATA_W  master 0 return data.
REQ-010 m0_readdatavalid  out  1  master 0 return strobe.
REQ-011 m1_address, m1_read, m1_waitrequest, m1_readdata, m1_readdatavalid: same directions, widths and meanings as REQ-006..010, for master 1.
REQ-012 s_address  out  ADDR_W  slave read address.
REQ-013 s_read  out  1  slave read request.
REQ-014 s_waitrequest  in  1  slave stall.
REQ-015 s_readdata  in  DATA_W  slave return data.
REQ-016 s_readdatavalid  in  1  slave return strobe.
REQ-017 outstanding  out  $clog2(MAX_OUTST+1)  count of accepted, unreturned reads.
REQ-018 err_orphan  out  1  sticky flag: slave returned data with no outstanding read.

Function
REQ-019 Accept definition: s_read && !s_waitrequest in the same cycle.
REQ-020 State: lock (1b), lock_id (1b), rr_pri (1b; master with priority), tag FIFO of master IDs (MAX_OUTST x 1b), err_orphan.
REQ-021 Grant selection, combinational:
  - lock=1: grant lock_id.
  - lock=0, one master requesting: grant that master.
  - lock=0, both requesting: grant rr_pri.
  - lock=0, neither requesting: no grant.
REQ-022 s_read = granted master's read && (outstanding < MAX_OUTST); s_address = granted master's address; s_address is 0 when there is no grant.
REQ-023 Waitrequest to the granted master = s_waitrequest || (outstanding == MAX_OUTST).
REQ-024 Waitrequest to the non-granted master = 1 whenever that master's read is asserted; otherwise 1 as well (constant stall while not granted).
REQ-025 Stalled issue: s_read && s_waitrequest -> next cycle lock=1, lock_id=granted ID. The grant does not switch while the slave stalls.
REQ-026 On accept, next cycle:
  - lock=0
  - rr_pri = inverse of the accepted ID
  - accepted ID pushed into the tag FIFO
REQ-027 FIFO full (outstanding == MAX_OUTST): s_read=0, lock unchanged, rr_pri unchanged; the granted master stays stalled.
REQ-028 Locked master deasserts read (protocol violation): lock clears next cycle, no push, rr_pri unchanged.
REQ-029 Return routing: s_readdata is driven to both m0_readdata and m1_readdata. On s_readdatavalid with outstanding>0, only the master at the FIFO head gets readdatavalid=1, same cycle; the head is popped.
REQ-030 Returns are in order; the FIFO preserves accept order, so data is delivered to masters in the order their reads were accepted.
REQ-031 s_readdatavalid with outstanding==0: no master strobed, err_orphan set to 1 next cycle. This applies even if an accept happens in the same cycle; that accept is still pushed.
REQ-032 Accept and return in the same cycle with outstanding>0: push and pop both occur; outstanding unchanged.
REQ-033 outstanding is registered and equals pushes minus pops. It never exceeds MAX_OUTST and never underflows.
REQ-034 Single slave port only; no address decode, no write path.

Reset
REQ-035 rst_n low, asynchronously: lock=0, lock_id=0, rr_pri=0, FIFO emptied, outstanding=0, err_orphan=0.
REQ-036 During reset: m0_readdatavalid=0, m1_readdatavalid=0. s_read and waitrequests follow REQ-022..024 from reset state.
REQ-037 Reset mid-operation discards all outstanding tags. Returns arriving after reset are orphans per REQ-031.

Verification
REQ-038 Reset, m0_read=1, address 0x10, s_waitrequest=0 -> same cycle s_read=1, s_address=0x10, m0_waitrequest=0; next cycle outstanding=1, rr_pri=1.
REQ-039 Both request every cycle, slave never stalls, 4 returns 2 cycles later -> accepts alternate m0,m1,m0,m1; readdatavalid strobes alternate m0,m1,m0,m1 with matching data.
REQ-040 m1 granted, s_waitrequest=1 for 3 cycles while m0 also requests -> s_address holds m1 address all 3 cycles; m0_waitrequest=1; m1 is accepted on cycle 4.
REQ-041 5 back-to-back requests, no returns -> 4 accepted, outstanding=4, 5th stalled with s_read=0; one return -> 5th accepted the next cycle, outstanding back to 4.
REQ-042 Return and accept in the same cycle at outstanding=2 -> outstanding stays 2; head ID strobed.
REQ-043 s_readdatavalid=1 at outstanding=0 -> no m*_readdatavalid; err_orphan=1 next cycle and held until rst_n low.
